// File: rtl/switch_port_buffer.sv
`default_nettype none
// ============================================================================
// Module   : switch_port_buffer
// Purpose  : Per-port egress packet buffer. Bytes from the switch core are
//            stored as whole packets; a packet becomes visible to the
//            downstream consumer only after its last byte is stored. Packets
//            that cannot fit (or that lose their eop) are dropped and counted.
// Ports    : clock, reset       - rising-edge clock, async active-high reset
//            wr_valid/data/sop/eop - byte stream from the switch core
//            read               - consumer pops the head byte (when ready)
//            port, port_last    - head byte and its eop flag (0 when !ready)
//            ready              - at least one complete packet stored
//            drop_count         - saturating count of dropped packets
// Revision : 1.0 - initial release
// ============================================================================
module switch_port_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_sop,
  input  logic        wr_eop,
  input  logic        read,
  output logic [7:0]  port,
  output logic        port_last,
  output logic        ready,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // {eop, data}
  logic [8:0]        mem [DEPTH];

  wr_state_t         state, state_nxt;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   pkt_start, pkt_start_nxt;
  logic [ADDR_W:0]   pkt_count;

  logic              full;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              pkt_done;
  logic              drop;
  logic              pop;
  logic              pop_last;
  logic [8:0]        head;

  // Occupancy is measured before this cycle's pop, so a same-cycle pop
  // never frees room for the same-cycle write.
  assign full     = (wr_ptr - rd_ptr) == DEPTH_C;
  assign head     = mem[rd_ptr[ADDR_W-1:0]];
  assign ready    = (pkt_count != '0);
  assign pop      = read & ready;
  assign pop_last = head[8];

  assign port      = ready ? head[7:0] : 8'h00;
  assign port_last = ready & head[8];

  // Write-side decisions for this cycle.
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    pkt_start_nxt = pkt_start;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr[ADDR_W-1:0];
    pkt_done      = 1'b0;
    drop          = 1'b0;
    if (wr_valid) begin
      case (state)
        IDLE: begin
          if (wr_sop) begin
            if (full) begin
              drop      = 1'b1;
              // A 1-byte packet is over already; nothing left to discard.
              state_nxt = wr_eop ? IDLE : DISCARD;
            end else begin
              wr_en         = 1'b1;
              pkt_start_nxt = wr_ptr;
              wr_ptr_nxt    = wr_ptr + 1'b1;
              if (wr_eop) pkt_done  = 1'b1;
              else        state_nxt = ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (wr_sop) begin
            // Missing eop: throw away the partial packet and restart the
            // new one at its start address. Room is guaranteed because the
            // partial packet held at least one entry.
            drop       = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = pkt_start[ADDR_W-1:0];
            wr_ptr_nxt = pkt_start + 1'b1;
            if (wr_eop) begin
              pkt_done  = 1'b1;
              state_nxt = IDLE;
            end
          end else if (full) begin
            drop       = 1'b1;
            wr_ptr_nxt = pkt_start;
            state_nxt  = wr_eop ? IDLE : DISCARD;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (wr_eop) begin
              pkt_done  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        DISCARD: begin
          if (wr_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_start  <= '0;
      pkt_count  <= '0;
      drop_count <= 16'h0000;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      pkt_start <= pkt_start_nxt;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous completion and last-byte pop leave the count unchanged.
      case ({pkt_done, pop & pop_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Storage carries no reset; contents are qualified by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= {wr_eop, wr_data};
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_port_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_port_buffer
// Purpose  : Directed self-checking bench for switch_port_buffer (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_port_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_sop = 1'b0;
  logic        wr_eop = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  port;
  logic        port_last;
  logic        ready;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  switch_port_buffer #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .read       (read),
    .port       (port),
    .port_last  (port_last),
    .ready      (ready),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic s, input logic e, input logic r);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sop   = s;
    wr_eop   = e;
    read     = r;
    step();
    wr_valid = 1'b0;
    wr_sop   = 1'b0;
    wr_eop   = 1'b0;
    read     = 1'b0;
  endtask

  // Check the head byte the consumer is about to sample, then pop it.
  task automatic take(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_port"},  32'(port), 32'(d));
    check({tag, "_last"},  32'(port_last), 32'(l));
    read = 1'b1;
    step();
    read = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_port"},  32'(port), 32'd0);
    check({tag, "_last"},  32'(port_last), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    expect_empty("rst");
    check("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // 1: three-byte packet, visible only after eop
    put(8'hA1, 1'b1, 1'b0, 1'b0);
    check("s1_ready_e1", 32'(ready), 32'd0);
    put(8'hA2, 1'b0, 1'b0, 1'b0);
    check("s1_ready_e2", 32'(ready), 32'd0);
    put(8'hA3, 1'b0, 1'b1, 1'b0);
    take("s1_a1", 8'hA1, 1'b0);
    take("s1_a2", 8'hA2, 1'b0);
    take("s1_a3", 8'hA3, 1'b1);
    expect_empty("s1_end");

    // 2: one-byte packet, then reads while empty are ignored
    put(8'h55, 1'b1, 1'b1, 1'b0);
    take("s2_55", 8'h55, 1'b1);
    expect_empty("s2_end");
    read = 1'b1;
    repeat (3) step();
    read = 1'b0;
    check("s2_idle_ready", 32'(ready), 32'd0);
    check("s2_idle_drop", 32'(drop_count), 32'd0);
    put(8'h66, 1'b1, 1'b1, 1'b0);
    take("s2_66", 8'h66, 1'b1);

    // 3: buffer full, next packet dropped at sop
    put(8'hB0, 1'b1, 1'b0, 1'b0);
    put(8'hB1, 1'b0, 1'b0, 1'b0);
    put(8'hB2, 1'b0, 1'b0, 1'b0);
    put(8'hB3, 1'b0, 1'b1, 1'b0);
    put(8'hC0, 1'b1, 1'b0, 1'b0);
    put(8'hC1, 1'b0, 1'b1, 1'b0);
    check("s3_drop", 32'(drop_count), 32'd1);
    take("s3_b0", 8'hB0, 1'b0);
    take("s3_b1", 8'hB1, 1'b0);
    take("s3_b2", 8'hB2, 1'b0);
    take("s3_b3", 8'hB3, 1'b1);
    expect_empty("s3_end");

    // 4: missing eop, partial packet replaced by the new one
    put(8'h10, 1'b1, 1'b0, 1'b0);
    put(8'h11, 1'b0, 1'b0, 1'b0);
    check("s4_ready_partial", 32'(ready), 32'd0);
    put(8'h20, 1'b1, 1'b0, 1'b0);
    put(8'h21, 1'b0, 1'b1, 1'b0);
    check("s4_drop", 32'(drop_count), 32'd2);
    take("s4_20", 8'h20, 1'b0);
    take("s4_21", 8'h21, 1'b1);
    expect_empty("s4_end");

    // Oversize packet (5 bytes > DEPTH) dropped at the full byte, then rewind
    put(8'h70, 1'b1, 1'b0, 1'b0);
    put(8'h71, 1'b0, 1'b0, 1'b0);
    put(8'h72, 1'b0, 1'b0, 1'b0);
    put(8'h73, 1'b0, 1'b0, 1'b0);
    put(8'h74, 1'b0, 1'b1, 1'b0);
    check("big_drop", 32'(drop_count), 32'd3);
    check("big_ready", 32'(ready), 32'd0);
    put(8'h77, 1'b1, 1'b1, 1'b0);
    take("big_77", 8'h77, 1'b1);

    // 5: B's eop written on the edge that pops A's last byte
    put(8'h30, 1'b1, 1'b0, 1'b0);
    put(8'h31, 1'b0, 1'b1, 1'b0);
    check("s5_a30", 32'(port), 32'h30);
    put(8'h40, 1'b1, 1'b0, 1'b1);
    check("s5_a31", 32'(port), 32'h31);
    check("s5_a31_last", 32'(port_last), 32'd1);
    put(8'h41, 1'b0, 1'b1, 1'b1);
    take("s5_40", 8'h40, 1'b0);
    take("s5_41", 8'h41, 1'b1);
    expect_empty("s5_end");

    // 6: asynchronous reset mid-drain
    put(8'hD0, 1'b1, 1'b0, 1'b0);
    put(8'hD1, 1'b0, 1'b1, 1'b0);
    put(8'hE0, 1'b1, 1'b1, 1'b0);
    take("s6_d0", 8'hD0, 1'b0);
    reset = 1'b1;
    #2;
    expect_empty("s6_arst");
    check("s6_arst_drop", 32'(drop_count), 32'd0);
    #1;
    reset = 1'b0;
    step();
    put(8'hA1, 1'b1, 1'b0, 1'b0);
    put(8'hA2, 1'b0, 1'b0, 1'b0);
    check("s6_ready_e2", 32'(ready), 32'd0);
    put(8'hA3, 1'b0, 1'b1, 1'b0);
    take("s6_a1", 8'hA1, 1'b0);
    take("s6_a2", 8'hA2, 1'b0);
    take("s6_a3", 8'hA3, 1'b1);
    expect_empty("s6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_port_buffer.md
# switch_port_buffer

Per-port egress buffer of the switch. It sits directly upstream of the output port seen by the port agent, between the switch core and the downstream consumer. It stores bytes from the switch core as whole packets and presents stored packets one byte at a time on `port` with `ready`. The downstream consumer pops each byte with `read`; a packet becomes visible only once its last byte has been stored.

## Interface
Parameters:
- `DEPTH`, 64: number of byte entries. Must be a power of 2, at least 4.
- `ADDR_W`, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `wr_valid`, in, 1: switch core presents a byte this cycle.
- `wr_data`, in, 8: byte from the switch core.
- `wr_sop`, in, 1: first byte of a packet. Qualified by `wr_valid`.
- `wr_eop`, in, 1: last byte of a packet. Qualified by `wr_valid`. A 1-byte packet has `wr_sop` and `wr_eop` both high.
- `read`, in, 1: consumer pops the head byte. Honoured only when `ready` = 1.
- `port`, out, 8: head byte. Forced to 0 when `ready` = 0.
- `port_last`, out, 1: head byte is the last byte of its packet. Forced to 0 when `ready` = 0.
- `ready`, out, 1: at least one complete packet is stored.
- `drop_count`, out, 16: number of dropped packets. Saturates at 16'hFFFF.

## Operation
- Storage is `DEPTH` entries of 9 bits: {eop, data}. Pointers are `wr_ptr`, `rd_ptr` and `pkt_start`, each `ADDR_W`+1 bits so that full and empty can be told apart.
- `pkt_count` is the number of complete packets stored. `ready` = (`pkt_count` != 0).
- Write FSM states:
  - IDLE: a byte with `wr_sop` is written, `pkt_start` is set to `wr_ptr`, and the FSM goes to ACCEPT. A byte without `wr_sop` is ignored. If the buffer is full when an sop byte arrives, the packet is dropped and the FSM goes to DISCARD.
  - ACCEPT: each byte is written. A byte with `wr_eop` increments `pkt_count` and returns the FSM to IDLE.
  - DISCARD: all bytes are ignored until a byte with `wr_eop`, then the FSM returns to IDLE.
- Drop in ACCEPT:
  - If the buffer is full when a byte arrives, `wr_ptr` rewinds to `pkt_start`, `drop_count` increments, and the FSM goes to DISCARD. If that byte carries `wr_eop`, the FSM goes to IDLE instead.
  - If a byte with `wr_sop` arrives in ACCEPT (missing eop), the partial packet is dropped: rewind, count the drop, and start the new packet at the rewound pointer in the same cycle.
- A dropped packet is never visible downstream. Packets longer than `DEPTH` are always dropped.
- Read side: on an edge with `read` & `ready`, `rd_ptr` increments. If the popped entry has eop set, `pkt_count` decrements. `read` with `ready` = 0 is ignored and changes no state.
- Same-cycle eop write and last-byte pop: `pkt_count` is unchanged, so `ready` stays high without a gap.
- Space check: "full" means (`wr_ptr` − `rd_ptr`) == `DEPTH`, evaluated before this cycle's pop. A pop in the same cycle does not free space for that cycle's write.

## Timing
- Reset values: `port` = 0, `port_last` = 0, `ready` = 0, `drop_count` = 0. All pointers are 0, `pkt_count` = 0, FSM is in IDLE. Storage contents are don't-care.
- Reset asserted mid-packet or mid-drain flushes everything immediately and asynchronously. The first valid write after release must carry `wr_sop`.
- Latency: an eop byte written at edge N raises `ready` after edge N; the consumer samples it at edge N+1.
- `port` and `port_last` are combinational from the entry at `rd_ptr`, gated by `ready`. They are stable from one edge to the next.
- `read` is sampled at the same edge as `port`. The byte seen at that edge is the byte consumed, and the next byte appears after that edge.
- Back-to-back `read` drains one byte per cycle. Packets are drained contiguously and never interleaved.
- `drop_count` updates one edge after the dropping byte.

## Test plan
- Reset, then one 3-byte packet 8'hA1, 8'hA2, 8'hA3 written on edges 1-3 -> `ready` = 0 through edge 3, `ready` = 1 from edge 4 with `port` = 8'hA1. `read` held high for 3 cycles -> consumer samples A1, A2, A3 with `port_last` = 1 on A3, then `ready` = 0 and `port` = 0.
- 1-byte packet 8'h55 (sop = eop = 1) -> `ready` = 1, `port_last` = 1. A single `read` empties the buffer. `read` held high while `ready` = 0 -> no pointer change, `drop_count` stays 0.
- `DEPTH` = 4; write a 4-byte packet, then a 2-byte packet without any reads -> second packet dropped, `drop_count` = 1. Draining returns only the first packet, then `ready` = 0.
- Packet 8'h10, 8'h11 without eop, followed by sop packet 8'h20, 8'h21 (eop) -> `drop_count` = 1, consumer receives only 20, 21.
- Continuous traffic: packet B's eop is written on the same edge that A's last byte is popped -> `ready` stays high and B's first byte appears on the next edge.
- `reset` pulsed asynchronously mid-drain with 2 packets stored -> `ready`, `port`, `port_last` and `drop_count` go to 0 immediately. A new packet afterwards behaves as in scenario 1.
